// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared state encoding, defaults and widths for the video line writer
package vid_pkg;

    localparam int LINE_W_DEF = 336;
    localparam int LINES_DEF  = 240;
    localparam int BUF_AW     = 10;
    localparam int X_W        = BUF_AW - 1;

    typedef logic [15:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        ACTIVE,
        LINE_DONE
    } vidlw_state_t;

endpackage

// File: rtl/vidlw_fsm.sv
// rtl/vidlw_fsm.sv - frame/line sequencing FSM with pixel x, line counter and write bank
module vidlw_fsm
    import vid_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int LINES  = LINES_DEF
) (
    input  logic           CLK_1H,
    input  logic           reset,
    input  logic           HBLANK_b,
    input  logic           VBLANK_b,
    output logic           pix_we,
    output logic [X_W-1:0] pix_x,
    output logic           write_bank,
    output logic [X_W-1:0] x,
    output logic [7:0]     line_cnt,
    output logic           line_done,
    output logic           frame_go
);

    localparam logic [X_W-1:0] LINE_W_X = X_W'(LINE_W);
    localparam logic [7:0]     LINES_L  = 8'(LINES);

    vidlw_state_t state, state_nx;
    logic         vblank_q;

    always_comb begin
        state_nx  = state;
        pix_we    = 1'b0;
        pix_x     = x;
        frame_go  = 1'b0;
        line_done = 1'b0;
        case (state)
            IDLE: begin
                if (VBLANK_b && !vblank_q) begin
                    state_nx = WAIT_LINE;
                    frame_go = 1'b1;
                end
            end
            WAIT_LINE: begin
                if (!VBLANK_b) begin
                    state_nx = IDLE;
                end else if (HBLANK_b && (line_cnt < LINES_L)) begin
                    // the first active pixel of the line is captured on entry
                    state_nx = ACTIVE;
                    pix_x    = '0;
                    pix_we   = 1'b1;
                end
            end
            ACTIVE: begin
                if (!VBLANK_b) begin
                    state_nx = IDLE;
                end else if (!HBLANK_b) begin
                    state_nx = LINE_DONE;
                end else if (x < LINE_W_X) begin
                    pix_we = 1'b1;
                end
            end
            LINE_DONE: begin
                state_nx  = WAIT_LINE;
                line_done = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // vblank_q resets high so a VBLANK_b already high at release is not taken as a rising edge
    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            vblank_q   <= 1'b1;
            x          <= '0;
            line_cnt   <= '0;
            write_bank <= 1'b0;
        end else begin
            state    <= state_nx;
            vblank_q <= VBLANK_b;
            if (pix_we) begin
                x <= pix_x + 1'b1;
            end
            if (frame_go) begin
                line_cnt <= '0;
            end else if (line_done) begin
                write_bank <= ~write_bank;
                if (line_cnt != 8'hFF) begin
                    line_cnt <= line_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vid_line_writer.sv
// rtl/vid_line_writer.sv - captures active video lines into a two-bank line buffer with reader handshake
// Defining VIDLW_STATS_EN adds the frame_cnt and ovr_cnt statistics outputs.
module vid_line_writer
    import vid_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    parameter int LINES  = LINES_DEF
) (
    input  logic              CLK_1H,
    input  logic              reset,
    input  logic [15:0]       VIDOUT,
    input  logic              HBLANK_b,
    input  logic              VBLANK_b,
    output logic              wr_en,
    output logic [BUF_AW-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              line_ready,
    output logic              line_bank,
    output logic [7:0]        line_num,
    output logic [8:0]        line_len,
    input  logic              line_ack,
    output logic              frame_start,
`ifdef VIDLW_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [7:0]        ovr_cnt,
`endif
    output logic              overrun
);

    logic           pix_we;
    logic [X_W-1:0] pix_x;
    logic           write_bank;
    logic [X_W-1:0] x;
    logic [7:0]     line_cnt;
    logic           line_done;
    logic           frame_go;
    logic           ovr_event;

    vidlw_fsm #(
        .LINE_W (LINE_W),
        .LINES  (LINES)
    ) u_fsm (
        .CLK_1H     (CLK_1H),
        .reset      (reset),
        .HBLANK_b   (HBLANK_b),
        .VBLANK_b   (VBLANK_b),
        .pix_we     (pix_we),
        .pix_x      (pix_x),
        .write_bank (write_bank),
        .x          (x),
        .line_cnt   (line_cnt),
        .line_done  (line_done),
        .frame_go   (frame_go)
    );

    // an ack arriving with the new line retires the old one, so only an unacked line is lost
    assign ovr_event = line_done && line_ready && !line_ack;

    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            frame_start <= 1'b0;
        end else begin
            wr_en       <= pix_we;
            frame_start <= frame_go;
            if (pix_we) begin
                wr_addr <= {write_bank, pix_x};
                wr_data <= VIDOUT;
            end
        end
    end

    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            line_ready <= 1'b0;
            line_bank  <= 1'b0;
            line_num   <= '0;
            line_len   <= '0;
            overrun    <= 1'b0;
        end else if (line_done) begin
            line_ready <= 1'b1;
            line_bank  <= write_bank;
            line_num   <= line_cnt;
            line_len   <= x;
            if (ovr_event) begin
                overrun <= 1'b1;
            end
        end else if (line_ready && line_ack) begin
            line_ready <= 1'b0;
        end
    end

`ifdef VIDLW_STATS_EN
    always_ff @(posedge CLK_1H or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
            ovr_cnt   <= '0;
        end else begin
            if (frame_go) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
            if (ovr_event && (ovr_cnt != 8'hFF)) begin
                ovr_cnt <= ovr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/vid_line_writer.md
VID_LINE_WRITER -- requirements
Module: vid_line_writer

Interface
REQ-001 The parameter LINE_W SHALL default to 336 and set the active pixels per line captured.
REQ-002 The parameter LINES SHALL default to 240 and set the active lines per frame.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 CLK_1H  in  1  pixel clock; all state changes on its rising edge.
REQ-005 VIDOUT  in  16  pixel colour from the graphics block, sampled each CLK_1H edge.
REQ-006 HBLANK_b  in  1  horizontal blank, active-low.
REQ-007 VBLANK_b  in  1  vertical blank, active-low.
REQ-008 wr_en  out  1  line-buffer write strobe.
REQ-009 wr_addr  out  10  {bank, x[8:0]} line-buffer write address.
REQ-010 wr_data  out  16  pixel written.
REQ-011 line_ready  out  1  a completed line is available to the VGA-side reader.
REQ-012 line_bank  out  1  bank holding the completed line.
REQ-013 line_num  out  8  index of the completed line within the frame.
REQ-014 line_len  out  9  pixels actually written for that line.
REQ-015 line_ack  in  1  reader accepts the line; consumed only while line_ready=1.
REQ-016 frame_start  out  1  one-cycle pulse at the start of each active frame.
REQ-017 overrun  out  1  sticky: a line completed while the previous one was unacknowledged.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_LINE, ACTIVE and LINE_DONE.
REQ-019 IDLE->WAIT_LINE on VBLANK_b rising edge; frame_start pulses the following cycle and the line counter clears to 0.
REQ-020 WAIT_LINE->ACTIVE on the first cycle with HBLANK_b=1 and VBLANK_b=1; x clears to 0.
REQ-021 In ACTIVE, each cycle with HBLANK_b=1 and x<LINE_W SHALL write VIDOUT to {write_bank, x} with wr_en one cycle later (1-cycle latency), then increment x.
REQ-022 Pixels arriving when x=LINE_W SHALL be dropped with no write, and x SHALL saturate at LINE_W.
REQ-023 ACTIVE->LINE_DONE on HBLANK_b falling edge; in LINE_DONE, line_ready=1, line_bank=write_bank, line_num=line counter and line_len=x SHALL be registered, write_bank toggles, the line counter increments (saturating at 255), then the FSM goes to WAIT_LINE.
REQ-024 line_ready SHALL stay high until a cycle with line_ack=1, then drop the next cycle.
REQ-025 If LINE_DONE occurs while line_ready=1 and no ack arrives in that cycle, the line info SHALL be replaced with the newest line's, line_ready SHALL stay 1, and overrun SHALL set.
REQ-026 An ack in the same cycle as a new LINE_DONE SHALL consume the old line, and line_ready SHALL remain 1 for the new line with no overrun.
REQ-027 A VBLANK_b falling edge in ACTIVE SHALL abort the line: no line_ready, write_bank unchanged, state IDLE.
REQ-028 After the line counter reaches LINES, the block SHALL ignore further lines until IDLE.
REQ-029 overrun SHALL clear only on reset.

Reset
REQ-030 On reset, the state SHALL be IDLE, and write_bank, x and the line counter SHALL be 0.
REQ-031 On reset, all outputs (wr_en, wr_addr, wr_data, line_ready, line_bank, line_num, line_len, frame_start, overrun) SHALL be 0.
REQ-032 A reset asserted mid-line SHALL discard all partial state, and no write SHALL issue after deassertion until the next VBLANK_b rising edge.

Configuration
REQ-033 With VIDLW_STATS_EN defined, output frame_cnt (16-bit, increments at each frame_start, wraps) and output ovr_cnt (8-bit, increments per overrun event, saturates at 255) SHALL exist; both reset to 0.
REQ-034 Without VIDLW_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-035 The shared package vid_pkg SHALL hold the FSM state enum, the LINE_W/LINES defaults, the pixel type (16-bit) and the buffer address width (10).
REQ-036 One sub-module, vidlw_fsm (state, x and line counters), SHALL be used; the output registers and the handshake SHALL live in the top module.

Verification
REQ-037 Reset, then VBLANK_b rise, then 336 active pixels with VIDOUT=x -> frame_start pulse; wr_addr 0..335 in bank 0 with wr_data=x; line_ready with line_len=336, line_num=0.
REQ-038 400-pixel active line -> exactly 336 writes, line_len=336, wr_addr never above 335.
REQ-039 Two lines with no line_ack -> overrun=1, line_bank=1, line_num=1; the third line is written to bank 0.
REQ-040 line_ack asserted in the cycle the second line completes -> line_ready stays 1, line_num=1, overrun=0.
REQ-041 VBLANK_b falls after 100 pixels -> no line_ready; the next frame's first line is written to the same bank and line_num=0.
REQ-042 Reset asserted mid-line, then with VIDLW_STATS_EN defined, 3 frames -> all outputs 0 after reset; frame_cnt=3, ovr_cnt=0.
